// File: rtl/fifo_ctrl_prog_if.sv
// Push/pop handshake bundle for fifo_ctrl_prog.
//   master : producer/consumer side (drives wr_en, din, rd_en; sees dout, dout_valid)
//   slave  : FIFO side (sees wr_en, din, rd_en; drives dout, dout_valid)
interface fifo_ctrl_prog_if #(
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  modport master (
    output wr_en, din, rd_en,
    input  dout, dout_valid
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, dout_valid
  );
endinterface

// File: rtl/fifo_ctrl_prog.sv
// Synchronous FIFO controller with internal storage, programmable
// almost-full/almost-empty thresholds, occupancy count, synchronous flush
// and sticky overflow/underflow flags.
//
// Compile-time option: define FIFO_CTRL_PROG_FWFT_EN for first-word-fall-
// through reads (dout = head word, dout_valid = !empty). Undefined gives a
// registered dout with a one-cycle dout_valid pulse after each accepted pop.
//
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   bus (slave)    wr_en/din push, rd_en pop, dout/dout_valid read data
//   flush          synchronous clear of pointers and count
//   af_thresh      almost_full when count >= af_thresh
//   ae_thresh      almost_empty when count <= ae_thresh
//   count          occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   status from registered count
//   overflow, underflow  sticky error flags, cleared by err_clr
module fifo_ctrl_prog #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  fifo_ctrl_prog_if.slave      bus,
  input  logic                 flush,
  input  logic [CNT_W-1:0]     af_thresh,
  input  logic [CNT_W-1:0]     ae_thresh,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);
  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic push_acc, pop_acc, push_rej, pop_rej;

  // Flags come only from the registered count, so wr_en/rd_en never reach them.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // Flush takes the cycle: nothing is accepted and nothing counts as rejected.
    push_acc = bus.wr_en & ~full  & ~flush;
    pop_acc  = bus.rd_en & ~empty & ~flush;
    push_rej = bus.wr_en &  full  & ~flush;
    pop_rej  = bus.rd_en &  empty & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    end

    // A new error event beats a simultaneous clear.
    overflow_d  = (overflow_q  & ~err_clr) | push_rej;
    underflow_d = (underflow_q & ~err_clr) | pop_rej;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= bus.din;
  end

`ifdef FIFO_CTRL_PROG_FWFT_EN
  // Head word is presented combinationally from storage.
  assign bus.dout       = mem[rd_ptr_q];
  assign bus.dout_valid = ~empty;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  always_comb begin
    dout_d       = pop_acc ? mem[rd_ptr_q] : dout_q;
    dout_valid_d = pop_acc;
  end

  // Read stage: popped word registered, one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`endif
endmodule

// File: tb/tb_fifo_ctrl_prog.sv
module tb_fifo_ctrl_prog;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             err_clr;
  logic [CNT_W-1:0] af_thresh;
  logic [CNT_W-1:0] ae_thresh;
  logic [CNT_W-1:0] count;
  logic             full, empty, almost_full, almost_empty;
  logic             overflow, underflow;

  fifo_ctrl_prog_if #(.DATA_W(DATA_W)) bus_if ();

  fifo_ctrl_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus_if),
    .flush        (flush),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a queue, errors as plain bits.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;
  bit                m_unf;
  logic [DATA_W-1:0] m_dout;
  bit                m_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input logic wr, input logic [DATA_W-1:0] d,
                                     input logic rd, input logic fl, input logic ec);
    bit was_full, was_empty;
    if (!rstn) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_dout = '0; m_dv = 0;
    end else if (fl) begin
      q.delete();
      m_dv = 0;
      if (ec) begin m_ovf = 0; m_unf = 0; end
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (ec) begin m_ovf = 0; m_unf = 0; end
      if (wr && was_full)  m_ovf = 1;
      if (rd && was_empty) m_unf = 1;
      m_dv = 0;
      if (rd && !was_empty) begin m_dout = q.pop_front(); m_dv = 1; end
      if (wr && !was_full) q.push_back(d);
    end
  endfunction

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), n);
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= int'(af_thresh)));
    chk("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_thresh)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_CTRL_PROG_FWFT_EN
    chk("dout_valid", 32'(bus_if.dout_valid), 32'(n != 0));
    if (n != 0) chk("dout_head", 32'(bus_if.dout), 32'(q[0]));
`else
    chk("dout_valid", 32'(bus_if.dout_valid), 32'(m_dv));
    chk("dout", 32'(bus_if.dout), 32'(m_dout));
`endif
  endtask

  task automatic cyc(input logic wr, input logic [DATA_W-1:0] d, input logic rd,
                     input logic fl, input logic ec);
    @(negedge clk);
    bus_if.wr_en = wr;
    bus_if.din   = d;
    bus_if.rd_en = rd;
    flush        = fl;
    err_clr      = ec;
    @(posedge clk);
    model_step(wr, d, rd, fl, ec);
    #1;
    check_all();
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; err_clr = 1'b0;
    af_thresh = 4'd6; ae_thresh = 4'd1;
    bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0; bus_if.din = '0;

    // Reset values
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h33, 1, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_dout_valid", 32'(bus_if.dout_valid), 0);
    rstn = 1'b1;

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      if (i == 5) chk("af_below_6", 32'(almost_full), 0);
      if (i == 6) chk("af_at_6", 32'(almost_full), 1);
      if (i == 7) chk("full_at_7", 32'(full), 0);
      if (i == 8) chk("full_at_8", 32'(full), 1);
    end

    // Overflow when full, then clear
    cyc(1, 8'hAA, 0, 0, 0);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_set", 32'(overflow), 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("ovf_clr", 32'(overflow), 0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_CTRL_PROG_FWFT_EN
      chk("fwft_head", 32'(bus_if.dout), i);
      cyc(0, 8'h00, 1, 0, 0);
`else
      cyc(0, 8'h00, 1, 0, 0);
      chk("drain_data", 32'(bus_if.dout), i);
      chk("drain_valid", 32'(bus_if.dout_valid), 1);
`endif
    end
    chk("drained_empty", 32'(empty), 1);

    // Underflow at empty
    cyc(0, 8'h00, 1, 0, 0);
    chk("unf_set", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
    cyc(0, 8'h00, 0, 0, 1);

    // Full boundary with simultaneous push/pop
    for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0, 0, 0);
    cyc(1, 8'hEE, 1, 0, 0);
    chk("fullrw_count", 32'(count), 7);
    chk("fullrw_ovf", 32'(overflow), 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("conc_start", 32'(count), 4);

    // Concurrent traffic across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'($urandom), 1, 0, 0);
      chk("conc_count", 32'(count), 4);
    end

    // Flush with write at count 5
    cyc(1, 8'($urandom), 0, 0, 0);
    chk("pre_flush", 32'(count), 5);
    cyc(1, 8'h77, 0, 1, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    cyc(0, 8'h00, 1, 0, 0);
    chk("flush_drop", 32'(underflow), 1);
    cyc(0, 8'h00, 0, 0, 1);

    // Reset mid-traffic at count 3
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0, 0);
    rstn = 1'b0;
    cyc(1, 8'h12, 1, 0, 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    rstn = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 25) begin
        af_thresh = 4'($urandom_range(0, 15));
        ae_thresh = 4'($urandom_range(0, 15));
      end
      rstn = ($urandom_range(0, 99) != 0);
      cyc(logic'($urandom_range(0, 99) < 55), 8'($urandom),
          logic'($urandom_range(0, 99) < 50),
          logic'($urandom_range(0, 99) < 3),
          logic'($urandom_range(0, 99) < 6));
      rstn = 1'b1;
    end
    af_thresh = 4'd6; ae_thresh = 4'd1;

`ifdef FIFO_CTRL_PROG_FWFT_EN
    // First-word fall-through presentation
    cyc(0, 8'h00, 0, 1, 1);
    cyc(1, 8'h5C, 0, 0, 0);
    chk("fwft_dout", 32'(bus_if.dout), 32'h5C);
    chk("fwft_valid", 32'(bus_if.dout_valid), 1);
    cyc(0, 8'h00, 1, 0, 0);
    chk("fwft_popped", 32'(bus_if.dout_valid), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
